ibex_mem_intg_responder: RTL and testbench

Memory-side responder for one Ibex instruction- or data-bus port. It accepts `req`/`gnt` requests and returns `rvalid` responses after a fixed latency. It holds a word-organised RAM and generates the 7 inverted-SECDED integrity bits alongside every 32-bit read word. When `MemECC` is set, it also checks the integrity bits on incoming write data. It is the producer of the `rdata`/`rdata_intg` pair that the core-side integrity merge consumes, and is used as the bench/FPGA memory model in both SecureIbex and non-secure configurations.

---
 rtl/ibex_mem_intg_responder_if.sv | 25 ++
 rtl/ibex_mem_intg_responder.sv | 88 ++++++++
 tb/tb_ibex_mem_intg_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ibex_mem_intg_responder_if.sv
// Request/response bus between an Ibex instruction- or data-port and the
// integrity-aware memory responder.
interface ibex_mem_intg_responder_if;
  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [6:0]  wdata_intg_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic [6:0]  rdata_intg_o;
  logic        err_o;

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i, wdata_intg_i,
    output gnt_o, rvalid_o, rdata_o, rdata_intg_o, err_o
  );

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i, wdata_intg_i,
    input  gnt_o, rvalid_o, rdata_o, rdata_intg_o, err_o
  );
endinterface

// File: rtl/ibex_mem_intg_responder.sv
// Word-organised RAM responder with fixed-latency responses, inverted-SECDED
// read integrity generation and optional write integrity checking.
module ibex_mem_intg_responder #(
  parameter bit          MemECC      = 1'b1,
  parameter int unsigned MemDepth    = 1024,
  parameter int unsigned RespLatency = 1
) (
  input logic                      clk_i,
  input logic                      rst_i,
  ibex_mem_intg_responder_if.slave bus
);
  localparam int unsigned AW   = $clog2(MemDepth);
  localparam int unsigned Last = RespLatency - 1;

  localparam logic [6:0]  IntgC = 7'h2A;
  localparam logic [31:0] IntgM [7] = '{
    32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
    32'hC2C1323B, 32'h2DCC624C, 32'h98505586
  };

  function automatic logic [6:0] intg(input logic [31:0] d);
    logic [6:0] r;
    r = '0;
    for (int unsigned k = 0; k < 7; k++) begin
      r[k] = ^(d & IntgM[k]);
    end
    return r ^ IntgC;
  endfunction

  logic [31:0]   mem [MemDepth];
  logic [AW-1:0] idx;
  logic          oor;
  logic          accept;
  logic          intg_bad;
  logic          req_err;
  logic          wr_en;
  logic [31:0]   data_in;

  logic [RespLatency-1:0]       pv;
  logic [RespLatency-1:0]       pe;
  logic [RespLatency-1:0][31:0] pd;

  always_comb begin
    idx      = bus.addr_i[2 +: AW];
    oor      = {2'b00, bus.addr_i[31:2]} >= MemDepth;
    accept   = bus.req_i & ~rst_i;
    intg_bad = MemECC & (bus.wdata_intg_i != intg(bus.wdata_i));
    req_err  = oor | (bus.we_i & intg_bad);
    wr_en    = accept & bus.we_i & ~req_err;
    // Write and error responses carry zero data so their integrity is intg(0).
    data_in  = (bus.we_i | req_err) ? '0 : mem[idx];
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus.be_i[b]) begin
          mem[idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pv <= '0;
      pe <= '0;
      pd <= '0;
    end else begin
      pv[0] <= accept;
      pe[0] <= req_err;
      pd[0] <= data_in;
      for (int unsigned i = 1; i < RespLatency; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  always_comb begin
    bus.gnt_o        = accept;
    bus.rvalid_o     = pv[Last];
    bus.err_o        = pv[Last] & pe[Last];
    bus.rdata_o      = pv[Last] ? pd[Last] : '0;
    bus.rdata_intg_o = intg(bus.rdata_o);
  end
endmodule

// File: tb/tb_ibex_mem_intg_responder.sv
// Directed bench for three responder configurations: (ECC,1024,lat1),
// (no ECC,16 words,lat3) and (ECC,1024,lat2).
module tb_ibex_mem_intg_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [3];
  logic        req   [3];
  logic        we    [3];
  logic [3:0]  be    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [6:0]  wintg [3];
  logic        gnt   [3];
  logic        rvalid[3];
  logic [31:0] rdata [3];
  logic [6:0]  rintg [3];
  logic        err   [3];

  int n_tests = 0;
  int n_fail  = 0;

  ibex_mem_intg_responder_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].req_i        = req[g];
    assign bus[g].we_i         = we[g];
    assign bus[g].be_i         = be[g];
    assign bus[g].addr_i       = addr[g];
    assign bus[g].wdata_i      = wdata[g];
    assign bus[g].wdata_intg_i = wintg[g];
    assign gnt[g]    = bus[g].gnt_o;
    assign rvalid[g] = bus[g].rvalid_o;
    assign rdata[g]  = bus[g].rdata_o;
    assign rintg[g]  = bus[g].rdata_intg_o;
    assign err[g]    = bus[g].err_o;

    ibex_mem_intg_responder #(
      .MemECC     (g != 1),
      .MemDepth   ((g == 1) ? 16 : 1024),
      .RespLatency((g == 0) ? 1 : ((g == 1) ? 3 : 2))
    ) u_dut (
      .clk_i(clk),
      .rst_i(rst[g]),
      .bus  (bus[g])
    );
  end

  function automatic logic [6:0] ref_intg(input logic [31:0] d);
    logic [31:0] m [7];
    logic [6:0]  r;
    m = '{32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
          32'hC2C1323B, 32'h2DCC624C, 32'h98505586};
    for (int k = 0; k < 7; k++) r[k] = ^(d & m[k]);
    return r ^ 7'h2A;
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input int d, input string tag, input logic wr, input logic [3:0] bm,
                      input logic [31:0] a, input logic [31:0] wd, input logic [6:0] wi,
                      input logic exp_err, input logic [31:0] exp_data, input logic [6:0] exp_intg);
    @(negedge clk);
    req[d] = 1'b1; we[d] = wr; be[d] = bm; addr[d] = a; wdata[d] = wd; wintg[d] = wi;
    #1 check({tag, ".gnt"}, {31'b0, gnt[d]}, 32'd1);
    @(negedge clk);
    req[d] = 1'b0;
    repeat (lat(d) - 1) @(negedge clk);
    check({tag, ".rvalid"}, {31'b0, rvalid[d]}, 32'd1);
    check({tag, ".err"}, {31'b0, err[d]}, {31'b0, exp_err});
    check({tag, ".rdata"}, rdata[d], exp_data);
    check({tag, ".rintg"}, {25'b0, rintg[d]}, {25'b0, exp_intg});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; req[d] = 1'b1; we[d] = 1'b0; be[d] = 4'hF;
      addr[d] = '0; wdata[d] = '0; wintg[d] = 7'h2A;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst%0d.gnt", d), {31'b0, gnt[d]}, 32'd0);
      check($sformatf("rst%0d.rvalid", d), {31'b0, rvalid[d]}, 32'd0);
      check($sformatf("rst%0d.err", d), {31'b0, err[d]}, 32'd0);
      check($sformatf("rst%0d.rdata", d), rdata[d], 32'd0);
      check($sformatf("rst%0d.rintg", d), {25'b0, rintg[d]}, 32'h2A);
      rst[d] = 1'b0;
      req[d] = 1'b0;
    end

    // Config A: ECC on, latency 1
    xfer(0, "a_wr0",    1'b1, 4'hF, 32'h0, 32'h0, 7'h2A, 1'b0, 32'h0, 7'h2A);
    xfer(0, "a_rd0",    1'b0, 4'hF, 32'h0, 32'h0, 7'h0,  1'b0, 32'h0, 7'h2A);
    xfer(0, "a_wrF",    1'b1, 4'hF, 32'h4, 32'hFFFFFFFF, 7'h2A, 1'b0, 32'h0, 7'h2A);
    xfer(0, "a_rdF",    1'b0, 4'hF, 32'h4, 32'h0, 7'h0, 1'b0, 32'hFFFFFFFF, 7'h2A);
    xfer(0, "a_be_w1",  1'b1, 4'hF, 32'h8, 32'h11223344, ref_intg(32'h11223344), 1'b0, 32'h0, 7'h2A);
    xfer(0, "a_be_w2",  1'b1, 4'b0101, 32'h8, 32'hAABBCCDD, ref_intg(32'hAABBCCDD), 1'b0, 32'h0, 7'h2A);
    xfer(0, "a_be_rd",  1'b0, 4'hF, 32'h8, 32'h0, 7'h0, 1'b0, 32'h11BB33DD, ref_intg(32'h11BB33DD));
    xfer(0, "a_old_w",  1'b1, 4'hF, 32'h40, 32'h55AA0F0F, ref_intg(32'h55AA0F0F), 1'b0, 32'h0, 7'h2A);
    xfer(0, "a_bad_w",  1'b1, 4'hF, 32'h40, 32'hDEADBEEF, ref_intg(32'hDEADBEEF) ^ 7'h01, 1'b1, 32'h0, 7'h2A);
    xfer(0, "a_bad_rd", 1'b0, 4'hF, 32'h40, 32'h0, 7'h0, 1'b0, 32'h55AA0F0F, ref_intg(32'h55AA0F0F));
    xfer(0, "a_oor_rd", 1'b0, 4'hF, 32'h1000, 32'h0, 7'h0, 1'b1, 32'h0, 7'h2A);
    xfer(0, "a_oor_w",  1'b1, 4'hF, 32'h1004, 32'h12345678, ref_intg(32'h12345678), 1'b1, 32'h0, 7'h2A);

    // Config B: ECC off, 16 words, latency 3
    for (int i = 0; i < 5; i++)
      xfer(1, $sformatf("b_fill%0d", i), 1'b1, 4'hF, 32'(i * 4), 32'hB00D0000 + 32'(i),
           7'h00, 1'b0, 32'h0, 7'h2A);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        check($sformatf("b_b2b%0d.rvalid", k), {31'b0, rvalid[1]}, {31'b0, (k >= 3 && k <= 7)});
        if (k >= 3 && k <= 7)
          check($sformatf("b_b2b%0d.rdata", k), rdata[1], 32'hB00D0000 + 32'(k - 3));
      end
      if (k < 5) begin
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'(k * 4);
        #1 check($sformatf("b_b2b%0d.gnt", k), {31'b0, gnt[1]}, 32'd1);
      end else begin
        req[1] = 1'b0;
      end
    end
    xfer(1, "b_noecc_w",  1'b1, 4'hF, 32'h20, 32'hDEADBEEF, ref_intg(32'hDEADBEEF) ^ 7'h01, 1'b0, 32'h0, 7'h2A);
    xfer(1, "b_noecc_rd", 1'b0, 4'hF, 32'h20, 32'h0, 7'h0, 1'b0, 32'hDEADBEEF, ref_intg(32'hDEADBEEF));
    xfer(1, "b_oor_rd",   1'b0, 4'hF, 32'h40, 32'h0, 7'h0, 1'b1, 32'h0, 7'h2A);

    // Config C: latency 2, reset with reads in flight
    for (int i = 0; i < 3; i++)
      xfer(2, $sformatf("c_fill%0d", i), 1'b1, 4'hF, 32'(i * 4), 32'hC0DE0000 + 32'(i * 4),
           ref_intg(32'hC0DE0000 + 32'(i * 4)), 1'b0, 32'h0, 7'h2A);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h0;
    @(negedge clk);
    addr[2] = 32'h4;
    @(negedge clk);
    check("c_rd0.rvalid", {31'b0, rvalid[2]}, 32'd1);
    check("c_rd0.rdata", rdata[2], 32'hC0DE0000);
    rst[2] = 1'b1; addr[2] = 32'h8;
    #1 check("c_rst.gnt", {31'b0, gnt[2]}, 32'd0);
    @(negedge clk);
    check("c_rst.rvalid", {31'b0, rvalid[2]}, 32'd0);
    check("c_rst.err", {31'b0, err[2]}, 32'd0);
    check("c_rst.rdata", rdata[2], 32'd0);
    check("c_rst.rintg", {25'b0, rintg[2]}, 32'h2A);
    rst[2] = 1'b0;
    #1 check("c_post.gnt", {31'b0, gnt[2]}, 32'd1);
    @(negedge clk);
    req[2] = 1'b0;
    check("c_post.early", {31'b0, rvalid[2]}, 32'd0);
    @(negedge clk);
    check("c_post.rvalid", {31'b0, rvalid[2]}, 32'd1);
    check("c_post.rdata", rdata[2], 32'hC0DE0008);
    check("c_post.rintg", {25'b0, rintg[2]}, {25'b0, ref_intg(32'hC0DE0008)});
    @(negedge clk);
    check("c_post.done", {31'b0, rvalid[2]}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
